// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data; define MEM_ARB_ROUND_ROBIN_EN for round-robin conflicts
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ID_FIFO_AW = 1
) (
  input  logic        clk,
  input  logic        res,
  input  logic        instr_req,
  input  logic [31:0] instr_adr,
  output logic        instr_gnt,
  output logic        instr_r_valid,
  output logic [31:0] instr_read,
  input  logic        data_req,
  input  logic [31:0] data_adr,
  input  logic        data_write_enable,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_write,
  output logic        data_gnt,
  output logic        data_r_valid,
  output logic [31:0] data_read,
  output logic        mem_req,
  output logic [31:0] mem_adr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        err
);
  localparam int DEPTH = 1 << ID_FIFO_AW;
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);
  logic                  locked, lock_d, lock_we;
  logic [31:0]           lock_adr, lock_wdata;
  logic [3:0]            lock_be;
  logic                  sel_d, cur_d, full, push, pop, nonempty, head_d;
  logic [DEPTH-1:0]      fifo;
  logic [ID_FIFO_AW-1:0] wptr, rptr;
  logic [3:0]            count;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d;
  always_ff @(posedge clk or posedge res)
    if (res) last_d <= 1'b0;
    else if (push) last_d <= cur_d;
  assign sel_d = data_req & (~instr_req | ~last_d);
`else
  assign sel_d = data_req;
`endif
  always_comb begin
    cur_d = locked ? lock_d : sel_d;
    full = count == MAX_CNT;
    nonempty = count != 4'd0;
    head_d = fifo[rptr];
    mem_req = ~full & (locked | instr_req | data_req);
    mem_adr = ~mem_req ? '0 : locked ? lock_adr : cur_d ? data_adr : instr_adr;
    mem_we = mem_req & (locked ? lock_we : cur_d & data_write_enable);
    mem_be = ~mem_req ? '0 : locked ? lock_be : cur_d ? data_be : 4'b1111;
    mem_wdata = ~mem_req ? '0 : locked ? lock_wdata : cur_d ? data_write : '0;
    push = mem_req & mem_gnt;
    pop = mem_rvalid & nonempty;
    instr_gnt = push & ~cur_d;
    data_gnt = push & cur_d;
    instr_r_valid = pop & ~head_d;
    data_r_valid = pop & head_d;
    instr_read = mem_rdata;
    data_read = mem_rdata;
  end
  // the payload is captured so mem_* stays put even if the requester lets go
  always_ff @(posedge clk or posedge res)
    if (res) begin
      locked <= 1'b0;
      lock_d <= 1'b0;
      lock_we <= 1'b0;
      lock_adr <= '0;
      lock_be <= '0;
      lock_wdata <= '0;
    end else begin
      locked <= mem_req & ~mem_gnt;
      if (mem_req & ~mem_gnt) begin
        lock_d <= cur_d;
        lock_we <= mem_we;
        lock_adr <= mem_adr;
        lock_be <= mem_be;
        lock_wdata <= mem_wdata;
      end
    end
  always_ff @(posedge clk or posedge res)
    if (res) begin
      fifo <= '0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      err <= 1'b0;
    end else begin
      if (push) fifo[wptr] <= cur_d;
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + {3'b0, push} - {3'b0, pop};
      if (mem_rvalid & ~nonempty) err <= 1'b1;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0, res;
  logic instr_req, instr_gnt, instr_r_valid;
  logic [31:0] instr_adr, instr_read;
  logic data_req, data_write_enable, data_gnt, data_r_valid;
  logic [31:0] data_adr, data_write, data_read;
  logic [3:0] data_be;
  logic mem_req, mem_we, mem_gnt, mem_rvalid, err;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  typedef struct {logic d; logic [31:0] data;} item_t;
  item_t sb[$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .res(res),
    .instr_req(instr_req), .instr_adr(instr_adr), .instr_gnt(instr_gnt),
    .instr_r_valid(instr_r_valid), .instr_read(instr_read),
    .data_req(data_req), .data_adr(data_adr), .data_write_enable(data_write_enable),
    .data_be(data_be), .data_write(data_write), .data_gnt(data_gnt),
    .data_r_valid(data_r_valid), .data_read(data_read),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic ir, input logic dr, input logic g, input logic rv);
    item_t it;
    @(posedge clk);
    #1;
    instr_req = ir;
    data_req = dr;
    mem_gnt = g;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    if (rv && sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (rv && sb.size() != 0) begin
      it = sb.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata = it.data;
      #1;
      chk("instr_r_valid", 32'(instr_r_valid), 32'(!it.d));
      chk("data_r_valid", 32'(data_r_valid), 32'(it.d));
      chk("read_data", it.d ? data_read : instr_read, it.data);
    end else #1;
  endtask
  task automatic grant(input logic d, input logic [31:0] rdata);
    chk("gnt_mem_req", 32'(mem_req), 32'd1);
    chk("instr_gnt", 32'(instr_gnt), 32'(!d));
    chk("data_gnt", 32'(data_gnt), 32'(d));
    chk("mem_adr", mem_adr, d ? data_adr : instr_adr);
    chk("mem_we", 32'(mem_we), d ? 32'(data_write_enable) : 32'd0);
    chk("mem_be", 32'(mem_be), d ? 32'(data_be) : 32'hf);
    chk("mem_wdata", mem_wdata, d ? data_write : 32'd0);
    sb.push_back('{d, rdata});
  endtask
  initial begin
    logic exp_d;
    res = 1'b1;
    instr_req = 0; data_req = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    instr_adr = 32'h100; data_adr = 32'h200; data_write_enable = 1'b1;
    data_be = 4'h3; data_write = 32'hDEADBEEF;
    #12;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_gnts", {30'd0, instr_gnt, data_gnt}, 32'd0);
    chk("rst_rvalids", {30'd0, instr_r_valid, data_r_valid}, 32'd0);
    chk("rst_payload", mem_adr | mem_wdata | 32'(mem_be) | 32'(mem_we), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1 res = 1'b0;
    drive(1, 0, 1, 0);
    grant(1'b0, 32'h00000013);
    drive(0, 0, 0, 1);
    chk("idle_mem_req", 32'(mem_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, i > 0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_d = (i % 2) == 0;
`else
      exp_d = 1'b1;
`endif
      grant(exp_d, 32'hC0000000 + 32'(i));
    end
    drive(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0);
      chk("lock_req", 32'(mem_req), 32'd1);
      chk("lock_gnts", {30'd0, instr_gnt, data_gnt}, 32'd0);
      chk("lock_adr", mem_adr, 32'h200);
    end
    drive(1, 0, 0, 0);
    data_adr = 32'h999; data_be = 4'h0; data_write_enable = 1'b0;
    #1;
    chk("held_adr", mem_adr, 32'h200);
    chk("held_be", 32'(mem_be), 32'h3);
    chk("held_we", 32'(mem_we), 32'd1);
    chk("held_instr_gnt", 32'(instr_gnt), 32'd0);
    drive(1, 0, 1, 0);
    chk("held_data_gnt", 32'(data_gnt), 32'd1);
    chk("held_instr_gnt2", 32'(instr_gnt), 32'd0);
    chk("held_adr2", mem_adr, 32'h200);
    sb.push_back('{1'b1, 32'hAAAA0000});
    data_adr = 32'h200; data_be = 4'h3; data_write_enable = 1'b1;
    drive(1, 0, 1, 0);
    grant(1'b0, 32'hBBBB0000);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    drive(1, 0, 1, 0);
    grant(1'b0, 32'hC1);
    drive(1, 0, 1, 0);
    grant(1'b0, 32'hC2);
    drive(1, 0, 1, 1);
    chk("full_mem_req", 32'(mem_req), 32'd0);
    chk("full_instr_gnt", 32'(instr_gnt), 32'd0);
    drive(1, 0, 1, 0);
    grant(1'b0, 32'hC3);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h5;
    #1;
    chk("err_rvalids", {30'd0, instr_r_valid, data_r_valid}, 32'd0);
    chk("err_before", 32'(err), 32'd0);
    drive(0, 0, 0, 0);
    chk("err_set", 32'(err), 32'd1);
    drive(0, 0, 0, 0);
    chk("err_sticky", 32'(err), 32'd1);
    drive(1, 0, 1, 0);
    grant(1'b0, 32'hD1);
    drive(1, 0, 1, 0);
    grant(1'b0, 32'hD2);
    drive(0, 0, 0, 0);
    res = 1'b1;
    #1;
    sb.delete();
    chk("res_err", 32'(err), 32'd0);
    chk("res_mem_req", 32'(mem_req), 32'd0);
    chk("res_gnts", {30'd0, instr_gnt, data_gnt}, 32'd0);
    chk("res_payload", mem_adr | mem_wdata | 32'(mem_be) | 32'(mem_we), 32'd0);
    drive(0, 0, 0, 0);
    res = 1'b0;
    drive(0, 0, 0, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    #1;
    chk("post_res_rvalids", {30'd0, instr_r_valid, data_r_valid}, 32'd0);
    drive(0, 0, 0, 0);
    chk("post_res_err", 32'(err), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port memory bus (req/gnt/rvalid handshake) between the CPU's instruction-fetch and data interfaces. It sits between `proc` and the SoC memory port. It arbitrates requests and holds each request stable until it is granted. It tracks outstanding transactions in an owner FIFO and routes each read response back to the requester that issued it.

## Interface

Parameters:
- MAX_OUTSTANDING, 2 — maximum accepted-but-unanswered transactions; 1..8.
- ID_FIFO_AW, 1 — log2 of FIFO storage depth; 2^ID_FIFO_AW >= MAX_OUTSTANDING.

Ports:
- clk  in  1  — single clock, rising edge.
- res  in  1  — asynchronous, active-high reset.
- instr_req  in  1  — fetch request.
- instr_adr  in  32  — fetch address.
- instr_gnt  out  1  — fetch accepted.
- instr_r_valid  out  1  — fetch data valid.
- instr_read  out  32  — fetch data.
- data_req  in  1  — data request.
- data_adr  in  32  — data address.
- data_write_enable  in  1  — 1 = store.
- data_be  in  4  — byte enables.
- data_write  in  32  — store data.
- data_gnt  out  1  — data accepted.
- data_r_valid  out  1  — data response valid (loads and stores).
- data_read  out  32  — load data.
- mem_req / mem_adr / mem_we / mem_be / mem_wdata  out  1/32/1/4/32  — downstream request.
- mem_gnt  in  1  — downstream accept.
- mem_rvalid  in  1  — downstream response.
- mem_rdata  in  32  — downstream read data.
- err  out  1  — sticky protocol error.

## Operation

- **Owner selection.**
  - Only instr requesting → owner = I.
  - Only data requesting → owner = D.
  - Both requesting → policy per Configuration.
- **Lock.** While `mem_req=1 && mem_gnt=0`, the `lock` register holds the current owner. Owner, `mem_adr`, `mem_we`, `mem_be` and `mem_wdata` are not re-arbitrated until the handshake completes. Lock clears on `mem_gnt`.
- **Instruction forwarding.** I owner drives `mem_we=0`, `mem_be=4'b1111`, `mem_wdata=0`.
- **Stall when full.** `mem_req=0` whenever FIFO count == MAX_OUTSTANDING. This applies even if `mem_rvalid` pops in the same cycle.
- **Grant return.** `mem_gnt` is returned combinationally to the owner only: `instr_gnt`/`data_gnt = mem_gnt & mem_req & owner match`.
- **Owner FIFO.**
  - Push owner ID on `mem_req & mem_gnt`.
  - Pop on `mem_rvalid`.
  - Simultaneous push and pop leaves count unchanged.
  - Read and write pointers wrap modulo 2^ID_FIFO_AW.
- **Response routing.**
  - `instr_r_valid = mem_rvalid & head==I`; `data_r_valid = mem_rvalid & head==D`.
  - `mem_rdata` is broadcast to both `instr_read` and `data_read`.
- **Error.** `mem_rvalid` with an empty FIFO sets `err`. The FIFO is not popped and both r_valid outputs stay 0. `err` clears only on `res`.
- **Reset.** `res` asserted mid-transaction drops all outstanding IDs. Responses arriving after reset release are flagged via `err`.

## Timing

- Reset values:
  - all outputs 0;
  - FIFO empty;
  - lock cleared;
  - RR last-grant = I, so D wins the first conflict.
- Request path is combinational: 0-cycle latency from `*_req` to `mem_req`, and from `mem_gnt` to `*_gnt`.
- Response path is combinational: 0-cycle latency from `mem_rvalid` to `*_r_valid`.
- Responses are in order. The earliest legal `mem_rvalid` is the cycle after `mem_gnt`.
- A requester must hold `req` and its payload stable until `gnt`. The lock guarantees `mem_*` stability even if the losing requester deasserts.
- Throughput: one grant per cycle while FIFO count < MAX_OUTSTANDING.

## Configuration

- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - on conflict, grant the requester not granted in the last handshake;
  - last-grant register updates on each `mem_req & mem_gnt`.
- Undefined: fixed priority, D always beats I. No last-grant register is synthesized.

## Test plan

- **Fetch only.** `instr_req` held with `instr_adr=0x100`; `mem_gnt=1`; `mem_rvalid` next cycle with `mem_rdata=0x00000013` → `instr_gnt=1` in the request cycle, `instr_r_valid=1` and `instr_read=0x13` the next cycle, `data_r_valid=0`.
- **Conflict.** Both requesting continuously, `mem_gnt=1` every cycle.
  - With RR: grants alternate D, I, D, I.
  - Without RR: D is granted every cycle while `data_req=1`.
- **Lock.** Both request with `mem_gnt=0` for 3 cycles, then `data_req` drops while still ungranted → owner and `mem_adr` remain unchanged until `mem_gnt`.
- **Full.** MAX_OUTSTANDING=2; two grants issued with no responses → `mem_req=0` on the third request, even if `mem_rvalid` arrives in that same cycle. `mem_req` reasserts the following cycle.
- **Ordering.** Issue D then I, responses `0xAAAA0000` then `0xBBBB0000` → `data_r_valid` with `0xAAAA0000` first, then `instr_r_valid` with `0xBBBB0000`.
- **Error and reset.** `mem_rvalid` with an empty FIFO → `err=1` and sticky, no r_valid asserted. Assert `res` with 2 transactions outstanding → all outputs 0 and FIFO empty.
